// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Time-multiplexed driver for an eight-digit, common-anode
//                7-segment display. Runs on the core clock with an internal
//                prescaler. The display word is snapshotted at every frame
//                boundary, so a single frame never mixes old and new values.
//                Anodes, segments and the decimal point are active low. After
//                each digit change there is a short all-off window that
//                prevents ghosting.
//                Optional build macro SEG7_LZ_BLANK_EN enables leading-zero
//                suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
    parameter int DIV         = 6250,  // core clocks per digit slot
    parameter int NDIG        = 8,     // digits scanned (1..8)
    parameter int BLANK_CYC   = 16,    // all-off clocks after each digit change
    parameter int BLINK_SHIFT = 5      // frame-counter bit that sets blink phase
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        en,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  blink,
    output logic [7:0]  an,
    output logic [6:0]  sev_out,
    output logic        dp_n,
    output logic        frame_tick
);

    localparam int c_presc_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int c_blank_w = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    localparam logic [c_presc_w-1:0] c_presc_max  = c_presc_w'(DIV - 1);
    localparam logic [c_blank_w-1:0] c_blank_load = c_blank_w'(BLANK_CYC);
    localparam logic [2:0]           c_idx_last   = 3'(NDIG - 1);

    // Scan state
    logic [c_presc_w-1:0] r_presc;
    logic [2:0]           r_idx;
    logic [c_blank_w-1:0] r_blank;
    logic [7:0]           r_frame_cnt;
    logic [31:0]          r_sh_data;
    logic [7:0]           r_sh_dp;

    // Registered outputs
    logic [7:0]           r_an;
    logic [6:0]           r_sev;
    logic                 r_dp_n;
    logic                 r_frame_tick;

    // Combinational helpers
    logic                 w_tick;
    logic                 w_frame_end;
    logic [3:0]           w_nib;
    logic [6:0]           w_seg;
    logic [7:0]           w_onehot_n;
    logic                 w_digit_on;
    logic [7:0]           w_an_nxt;
    logic [6:0]           w_sev_nxt;
    logic                 w_dp_n_nxt;

    assign w_tick      = (r_presc == c_presc_max);
    assign w_frame_end = w_tick && (r_idx == c_idx_last);
    assign w_nib       = r_sh_data[{r_idx, 2'b00} +: 4];
    // r_idx never reaches NDIG, so anode bits at or above NDIG stay high
    assign w_onehot_n  = ~(8'd1 << r_idx);
    assign w_digit_on  = en && (r_blank == '0)
                         && !(blink[r_idx] && r_frame_cnt[BLINK_SHIFT]);

`ifdef SEG7_LZ_BLANK_EN
    // w_upper_zero[d]: shadow nibbles d..NDIG-1 are all zero
    logic [7:0] w_upper_zero;
    logic       w_supp;

    for (genvar d = 0; d < 8; d++) begin : g_lz
        if (d < NDIG) begin : g_used
            assign w_upper_zero[d] = ~|r_sh_data[4*NDIG-1 : 4*d];
        end else begin : g_unused
            assign w_upper_zero[d] = 1'b1;
        end
    end

    // Digit 0 is never suppressed so a zero word still shows a single "0"
    assign w_supp = (r_idx != 3'd0) && w_upper_zero[r_idx];
`endif

    // Hex nibble to active-low {a,b,c,d,e,f,g}
    always_comb begin
        w_seg = 7'h7F;
        case (w_nib)
            4'h0: w_seg = 7'b0000001;
            4'h1: w_seg = 7'b1001111;
            4'h2: w_seg = 7'b0010010;
            4'h3: w_seg = 7'b0000110;
            4'h4: w_seg = 7'b1001100;
            4'h5: w_seg = 7'b0100100;
            4'h6: w_seg = 7'b0100000;
            4'h7: w_seg = 7'b0001111;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0000100;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b1100000;
            4'hC: w_seg = 7'b0110001;
            4'hD: w_seg = 7'b1000010;
            4'hE: w_seg = 7'b0110000;
            4'hF: w_seg = 7'b0111000;
            default: w_seg = 7'h7F;
        endcase
    end

    // Next output values for the digit currently selected by r_idx
    always_comb begin
        w_an_nxt   = 8'hFF;
        w_sev_nxt  = 7'h7F;
        w_dp_n_nxt = 1'b1;
        if (w_digit_on) begin
`ifdef SEG7_LZ_BLANK_EN
            if (!w_supp) begin
                w_an_nxt   = w_onehot_n;
                w_sev_nxt  = w_seg;
                w_dp_n_nxt = ~r_sh_dp[r_idx];
            end else if (r_sh_dp[r_idx]) begin
                // Suppressed digit with its point set: light only the point
                w_an_nxt   = w_onehot_n;
                w_dp_n_nxt = 1'b0;
            end
`else
            w_an_nxt   = w_onehot_n;
            w_sev_nxt  = w_seg;
            w_dp_n_nxt = ~r_sh_dp[r_idx];
`endif
        end
    end

    // Prescaler, digit index, anti-ghost window, frame counter and snapshot
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_presc      <= '0;
            r_idx        <= 3'd0;
            r_blank      <= '0;
            r_frame_cnt  <= 8'd0;
            r_sh_data    <= 32'd0;
            r_sh_dp      <= 8'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;

            if (w_tick) begin
                r_idx   <= (r_idx == c_idx_last) ? 3'd0 : r_idx + 3'd1;
                r_blank <= c_blank_load;
            end else if (r_blank != '0) begin
                r_blank <= r_blank - 1'b1;
            end

            if (w_frame_end) begin
                r_sh_data   <= data_in;
                r_sh_dp     <= dp_in;
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end

            r_frame_tick <= w_frame_end;
        end
    end

    // Output registers: one clock behind the scan state they reflect
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_an   <= 8'hFF;
            r_sev  <= 7'h7F;
            r_dp_n <= 1'b1;
        end else begin
            r_an   <= w_an_nxt;
            r_sev  <= w_sev_nxt;
            r_dp_n <= w_dp_n_nxt;
        end
    end

    assign an         = r_an;
    assign sev_out    = r_sev;
    assign dp_n       = r_dp_n;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Directed self-checking bench for seg7_scan_driver with
//                DIV=4, BLANK_CYC=1, NDIG=8, BLINK_SHIFT=0. Each frame is
//                32 clocks. Every slot shows one blank sample followed by
//                three lit samples. Build with SEG7_LZ_BLANK_EN defined to
//                check leading-zero suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        Rst;
    logic        en;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  blink;
    logic [7:0]  an;
    logic [6:0]  sev_out;
    logic        dp_n;
    logic        frame_tick;

    int          n_total = 0;
    int          n_bad   = 0;

    // Bench view of what the DUT should have snapshotted, and its frame count
    logic [31:0] sh_data;
    logic [7:0]  sh_dp;
    int          fcnt;

    seg7_scan_driver #(
        .DIV        (4),
        .NDIG       (8),
        .BLANK_CYC  (1),
        .BLINK_SHIFT(0)
    ) u_dut (
        .clk       (clk),
        .Rst       (Rst),
        .en        (en),
        .data_in   (data_in),
        .dp_in     (dp_in),
        .blink     (blink),
        .an        (an),
        .sev_out   (sev_out),
        .dp_n      (dp_n),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // Expected {an, sev_out, dp_n, frame_tick} at sample k (1..32) of a frame
    function automatic logic [16:0] exp_sample(input int k, input logic en_m);
        int         p;
        int         s;
        logic       lit;
        logic       supp;
        logic [3:0] nib;
        logic [7:0] an_e;
        logic [6:0] sev_e;
        logic       dp_e;
        p     = (k - 1) % 4;
        s     = (k - 1) / 4;
        nib   = sh_data[4*s +: 4];
        an_e  = 8'hFF;
        sev_e = 7'h7F;
        dp_e  = 1'b1;
        lit   = en_m && (p != 0) && !(blink[s] && ((fcnt % 2) == 1));
`ifdef SEG7_LZ_BLANK_EN
        supp  = (s > 0) && ((sh_data >> (4 * s)) == 32'd0);
`else
        supp  = 1'b0;
`endif
        if (lit && !supp) begin
            an_e  = ~(8'd1 << s);
            sev_e = seg_of(nib);
            dp_e  = ~sh_dp[s];
        end else if (lit && supp && sh_dp[s]) begin
            an_e  = ~(8'd1 << s);
            dp_e  = 1'b0;
        end
        return {an_e, sev_e, dp_e, (k == 32)};
    endfunction

    // Starts right after a frame_tick sample; ends on the next one.
    // Optionally changes data_in / en after sample chg_k / en_k.
    task automatic check_frame(input int chg_k, input logic [31:0] chg_data,
                               input int en_k, input logic en_v);
        logic en_m;
        en_m = en;
        for (int k = 1; k <= 32; k++) begin
            step();
            chk($sformatf("frame%0d_k%0d", fcnt, k),
                {15'd0, an, sev_out, dp_n, frame_tick},
                {15'd0, exp_sample(k, en_m)});
            if (k == chg_k) data_in = chg_data;
            if (k == en_k) begin
                en   = en_v;
                en_m = en_v;
            end
        end
        sh_data = data_in;
        sh_dp   = dp_in;
        fcnt++;
    endtask

    // Bounded wait for the next frame_tick; n = samples taken
    task automatic wait_ft(output int n);
        n = 0;
        while (n < 200) begin
            step();
            n++;
            if (frame_tick === 1'b1) break;
        end
        if (frame_tick !== 1'b1) chk("ft_timeout", 32'd0, 32'd1);
        sh_data = data_in;
        sh_dp   = dp_in;
        fcnt++;
    endtask

    // Called on the negedge where Rst is released: digit 0 lit for the
    // first full slot, first tick on the 4th edge, then idx=1
    task automatic after_reset_seq(input string tag);
        logic [15:0] ex [6];
        int          n;
        ex[0] = {8'hFE, 7'b0000001, 1'b1};
        ex[1] = {8'hFE, 7'b0000001, 1'b1};
        ex[2] = {8'hFE, 7'b0000001, 1'b1};
        ex[3] = {8'hFE, 7'b0000001, 1'b1};
        ex[4] = {8'hFF, 7'h7F,      1'b1};
        ex[5] = {8'hFD, 7'b0000001, 1'b1};
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("%s_s%0d", tag, i), {16'd0, an, sev_out, dp_n}, {16'd0, ex[i]});
        end
        wait_ft(n);
        chk($sformatf("%s_first_ft", tag), n, 26);
    endtask

    initial begin
        Rst     = 1'b1;
        en      = 1'b1;
        data_in = 32'd0;
        dp_in   = 8'd0;
        blink   = 8'd0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_vals", {15'd0, an, sev_out, dp_n, frame_tick}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});

        // Basic scan: first frame shows zeros, then 89ABCDEF
        data_in = 32'h89ABCDEF;
        Rst     = 1'b0;
        sh_data = 32'd0;
        sh_dp   = 8'd0;
        fcnt    = 0;
        after_reset_seq("rel1");
        check_frame(0, 32'd0, 0, 1'b1);

        // Hand spot checks on the next frame
        data_in = 32'h11111111;
        step(); step();
        chk("d0_F", {16'd0, an, sev_out, dp_n}, {16'd0, 8'hFE, 7'b0111000, 1'b1});
        repeat (29) step();
        chk("d7_8", {16'd0, an, sev_out, dp_n}, {16'd0, 8'h7F, 7'b0000000, 1'b1});
        step();
        chk("ft_period", {31'd0, frame_tick}, 32'd1);
        sh_data = data_in;
        sh_dp   = dp_in;
        fcnt++;

        // No tearing: 11111111 frame, data changes while idx=3
        check_frame(14, 32'h22222222, 0, 1'b1);

        // Decimal point on digit 2 after the next snapshot
        dp_in = 8'h04;
        check_frame(0, 32'd0, 0, 1'b1);
        data_in = 32'h000000A5;
        dp_in   = 8'h80;
        check_frame(0, 32'd0, 0, 1'b1);

        // Leading zeros (suppressed only with the macro), then an all-zero word
        data_in = 32'd0;
        dp_in   = 8'd0;
        check_frame(0, 32'd0, 0, 1'b1);
        data_in = 32'h12345678;
        check_frame(0, 32'd0, 0, 1'b1);

        // Blink digit 0: lit on even frames only
        blink = 8'h01;
        check_frame(0, 32'd0, 0, 1'b1);
        check_frame(0, 32'd0, 0, 1'b1);
        blink = 8'h00;

        // Enable off mid-slot, then back on mid-slot; frame_tick keeps going
        check_frame(0, 32'd0, 10, 1'b0);
        check_frame(0, 32'd0, 18, 1'b1);

        // Asynchronous reset between edges while digit 0 is lit
        step(); step(); step();
        chk("pre_rst_lit", {24'd0, an}, {24'd0, 8'hFE});
        #2;
        Rst = 1'b1;
        #1;
        chk("async_rst", {15'd0, an, sev_out, dp_n, frame_tick}, {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        Rst     = 1'b0;
        sh_data = 32'd0;
        sh_dp   = 8'd0;
        fcnt    = 0;
        after_reset_seq("rel2");
        check_frame(0, 32'd0, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
